// File: rtl/tensor_core_pkg.sv
// Shared sizes, FSM encoding and element packing for the tiny tensor core.
// Matrices are 4x4 signed 4-bit elements packed row-major from the MSB.
package tensor_core_pkg;

  localparam int DIM    = 4;
  localparam int ELEM_W = 4;
  localparam int PROD_W = 8;
  localparam int ACC_W  = 10;
  localparam int MAT_W  = DIM * DIM * ELEM_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    DONE
  } state_e;

  // LSB of element (i,j): ((3-i)*4 + (3-j))*4, and 3-x is ~x on 2 bits
  function automatic logic [5:0] elem_lsb(
    input logic [1:0] i,
    input logic [1:0] j
  );
    return {~i, ~j, 2'b00};
  endfunction

endpackage

// File: rtl/tiny_tensor_core_if.sv
// Operand/result bundle between a host and the tiny tensor core.
// The host drives operands and the strobe; the core returns C and done.
interface tiny_tensor_core_if;
  import tensor_core_pkg::*;

  logic             tensor_core_register_file_write_enable;
  logic [MAT_W-1:0] tensor_core_input1;
  logic [MAT_W-1:0] tensor_core_input2;
  logic [MAT_W-1:0] tensor_core_output;
  logic             is_done_with_calculation;

  modport master (
    output tensor_core_register_file_write_enable,
    output tensor_core_input1,
    output tensor_core_input2,
    input  tensor_core_output,
    input  is_done_with_calculation
  );

  modport slave (
    input  tensor_core_register_file_write_enable,
    input  tensor_core_input1,
    input  tensor_core_input2,
    output tensor_core_output,
    output is_done_with_calculation
  );

endinterface

// File: rtl/tensor_mac.sv
// One signed 4x4-bit multiply into a 10-bit wrapping accumulator.
// o_res is the low element bits of the value the accumulator is about to take.
module tensor_mac
  import tensor_core_pkg::*;
(
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [ELEM_W-1:0] i_a,
  input  logic signed [ELEM_W-1:0] i_b,
  output logic        [ELEM_W-1:0] o_res
);

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_next;

  assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);
  assign w_next = r_acc + ACC_W'(w_prod);
  assign o_res  = w_next[ELEM_W-1:0];

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

endmodule

// File: rtl/tiny_tensor_core.sv
// 4x4 signed 4-bit matrix multiply: LOAD, four CALC steps, one-cycle DONE.
// A strobe in any state restarts; results land in C on entry to DONE.
module tiny_tensor_core
  import tensor_core_pkg::*;
(
  input  logic          clock_in,
  input  logic          reset_in,
  tiny_tensor_core_if.slave bus
);

  state_e           r_state;
  logic [1:0]       r_k;
  logic [MAT_W-1:0] r_a;
  logic [MAT_W-1:0] r_b;
  logic [MAT_W-1:0] r_out;
  logic             r_done;

  logic             w_we;
  logic             w_clr;
  logic             w_en;
  logic [MAT_W-1:0] w_c_next;

  assign w_we  = bus.tensor_core_register_file_write_enable;
  assign w_clr = (r_state == LOAD);
  assign w_en  = (r_state == CALC);

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      localparam logic [5:0] LSB = elem_lsb(2'(i), 2'(j));

      logic signed [ELEM_W-1:0] w_a;
      logic signed [ELEM_W-1:0] w_b;

      // Column k of A and row k of B feed every cell this step
      assign w_a = r_a[elem_lsb(2'(i), r_k) +: ELEM_W];
      assign w_b = r_b[elem_lsb(r_k, 2'(j)) +: ELEM_W];

      tensor_mac u_mac (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .i_clr    (w_clr),
        .i_en     (w_en),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_res    (w_c_next[LSB +: ELEM_W])
      );
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: r_state <= IDLE;
        LOAD: begin
          r_a     <= bus.tensor_core_input1;
          r_b     <= bus.tensor_core_input2;
          r_k     <= '0;
          r_state <= CALC;
        end
        CALC: begin
          r_k <= r_k + 2'd1;
          if (r_k == 2'd3 && !w_we) begin
            r_out   <= w_c_next;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_we) begin
        r_state <= LOAD;
      end
    end
  end

  assign bus.tensor_core_output       = r_out;
  assign bus.is_done_with_calculation = r_done;

endmodule

// File: tb/tb_tiny_tensor_core.sv
// Randomised bench for tiny_tensor_core against a plain matrix-product model.
// Covers latency, done width, wrap, restart, reset abort and output hold.
module tb_tiny_tensor_core;
  import tensor_core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  tiny_tensor_core_if bus ();

  tiny_tensor_core dut (
    .clock_in (clk),
    .reset_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int elem(input logic [63:0] m, input int i, input int j);
    logic [3:0] e;
    e = m[((3 - i) * 4 + (3 - j)) * 4 +: 4];
    return int'($signed(e));
  endfunction

  function automatic logic [63:0] matmul(input logic [63:0] a,
                                         input logic [63:0] b);
    logic [63:0] c = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int s = 0;
        for (int k = 0; k < 4; k++) s += elem(a, i, k) * elem(b, k, j);
        c[((3 - i) * 4 + (3 - j)) * 4 +: 4] = s[3:0];
      end
    end
    return c;
  endfunction

  function automatic logic [63:0] fill(input logic [3:0] v);
    logic [63:0] m;
    for (int n = 0; n < 16; n++) m[n * 4 +: 4] = v;
    return m;
  endfunction

  task automatic strobe(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.tensor_core_input1 = a;
    bus.tensor_core_input2 = b;
    bus.tensor_core_register_file_write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.tensor_core_register_file_write_enable = 1'b0;
  endtask

  // Watch a bounded window after a strobe edge
  task automatic watch(input string tag, input logic [63:0] exp);
    int first = -1;
    int cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.is_done_with_calculation === 1'b1) begin
        cnt++;
        if (first < 0) begin
          first = c;
          check({tag, "_c"}, bus.tensor_core_output, exp);
        end
      end
    end
    check({tag, "_lat"}, 64'(first), 64'd5);
    check({tag, "_cnt"}, 64'(cnt), 64'd1);
  endtask

  task automatic run(input string tag, input logic [63:0] a,
                     input logic [63:0] b);
    strobe(a, b);
    watch(tag, matmul(a, b));
  endtask

  logic [63:0] a, b, last;

  initial begin
    bus.tensor_core_register_file_write_enable = 1'b0;
    bus.tensor_core_input1 = '0;
    bus.tensor_core_input2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", bus.tensor_core_output, 64'd0);
    check("rst_done", 64'(bus.is_done_with_calculation), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    a = '0;
    b = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[((3 - i) * 4 + (3 - j)) * 4 +: 4] = (i == j) ? 4'd1 : 4'd0;
        b[((3 - i) * 4 + (3 - j)) * 4 +: 4] = 4'(i * 4 + j - 8);
      end
    strobe(a, b);
    watch("ident", b);
    run("ones", 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111);
    check("ones_c", bus.tensor_core_output, 64'h4444_4444_4444_4444);
    run("wrap23", fill(4'd2), fill(4'd3));
    check("wrap23_c", bus.tensor_core_output, fill(4'h8));
    run("wrap77", fill(4'd7), fill(4'd7));
    check("wrap77_c", bus.tensor_core_output, fill(4'h4));

    for (int n = 0; n < 10; n++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      run("rand", a, b);
    end

    // Restart two steps into CALC; first run must stay invisible
    last = bus.tensor_core_output;
    strobe({$urandom, $urandom}, {$urandom, $urandom});
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("rs_nodone", 64'(bus.is_done_with_calculation), 64'd0);
      check("rs_hold", bus.tensor_core_output, last);
    end
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run("restart", a, b);

    // Reset mid-CALC
    strobe({$urandom, $urandom}, {$urandom, $urandom});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check("mrst_out", bus.tensor_core_output, 64'd0);
      check("mrst_done", 64'(bus.is_done_with_calculation), 64'd0);
    end
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    run("post_rst", a, b);

    // Operands move without a strobe: nothing may change
    last = matmul(a, b);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.tensor_core_input1 = {$urandom, $urandom};
      bus.tensor_core_input2 = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check("hold_out", bus.tensor_core_output, last);
      check("hold_done", 64'(bus.is_done_with_calculation), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
